us_ping_scheduler: RTL and testbench

- Sequences the three single-pin ultrasonic rangers (front, side-front, side-back) so that only one is ever pinging, which prevents acoustic crosstalk between them.
- For each sensor in turn, it issues the trigger, times the echo, and converts the echo width to whole centimetres without a divider.
- Publishes one latched 8-bit distance per sensor to the navigation and localization blocks.
- Sits between the top-level tristate pins and the consumers of DISTANCE_FRONT, DISTANCE_SIDE_FRONT and DISTANCE_SIDE_BACK.

---
 rtl/us_sched_pkg.sv | 34 +++
 rtl/us_echo_timer.sv | 50 +++++
 rtl/us_ping_scheduler.sv | 143 ++++++++++++++
 tb/tb_us_ping_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/us_sched_pkg.sv
// rtl/us_sched_pkg.sv - shared types, sensor indices and round-robin helper for the ping scheduler
package us_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        HOLDOFF,
        WAIT_RISE,
        MEASURE,
        DONE,
        FAIL,
        GUARD
    } sched_state_t;

    localparam logic [1:0] US_FRONT      = 2'd0;
    localparam logic [1:0] US_SIDE_FRONT = 2'd1;
    localparam logic [1:0] US_SIDE_BACK  = 2'd2;

    localparam logic [7:0] DIST_MAX = 8'd255;

    // First enabled sensor at or after start, wrapping modulo 3; lowest offset wins.
    function automatic logic [1:0] next_sel(input logic [2:0] en, input logic [1:0] start);
        logic [2:0] s;
        next_sel = start;
        for (int k = 2; k >= 0; k--) begin
            s = {1'b0, start} + 3'(k);
            if (s >= 3'd3)
                s = s - 3'd3;
            if (en[s[1:0]])
                next_sel = s[1:0];
        end
    endfunction

endpackage

// File: rtl/us_echo_timer.sv
// rtl/us_echo_timer.sv - echo synchronizer and divider-free echo-width to centimetre counter
module us_echo_timer
    import us_sched_pkg::*;
#(
    parameter int CYCLES_PER_CM = 2900
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] echo_in,
    input  logic [1:0] sel,
    input  logic       clear,
    input  logic       count_en,
    output logic       echo_sync,
    output logic [7:0] cm
);

    localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [SUB_W-1:0] sub_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1   <= 3'b000;
            sync2   <= 3'b000;
            sub_cnt <= '0;
            cm      <= 8'd0;
        end else begin
            sync1 <= echo_in;
            sync2 <= sync1;
            if (clear) begin
                sub_cnt <= '0;
                cm      <= 8'd0;
            end else if (count_en) begin
                // Whole centimetres only: the partial sub-count is simply dropped at the end.
                if (sub_cnt == SUB_W'(CYCLES_PER_CM - 1)) begin
                    sub_cnt <= '0;
                    if (cm != DIST_MAX)
                        cm <= cm + 8'd1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end
        end
    end

    assign echo_sync = sync2[sel];

endmodule

// File: rtl/us_ping_scheduler.sv
// rtl/us_ping_scheduler.sv - round-robin trigger/echo sequencer for three single-pin ultrasonic rangers
module us_ping_scheduler
    import us_sched_pkg::*;
#(
    parameter int TRIG_CYCLES    = 250,
    parameter int HOLDOFF_CYCLES = 37500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GUARD_CYCLES   = 500000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] EN,
    input  logic [2:0] ECHO_IN,
    output logic [2:0] TRIG_OUT,
    output logic [2:0] TRIG_OE,
    output logic [7:0] DISTANCE_FRONT,
    output logic [7:0] DISTANCE_SIDE_FRONT,
    output logic [7:0] DISTANCE_SIDE_BACK,
    output logic [2:0] VALID,
    output logic [2:0] TIMEOUT,
    output logic       BUSY
);

    sched_state_t state;
    logic [1:0]   idx;
    logic [1:0]   rr_ptr;
    logic [1:0]   pick;
    logic [31:0]  cnt;
    logic         echo_sync;
    logic [7:0]   cm;
    logic         timer_clear;
    logic         timer_count;
    logic [7:0]   dist_wr;

    assign pick        = next_sel(EN, rr_ptr);
    assign timer_clear = (state == HOLDOFF);
    // The rising cycle seen in WAIT_RISE is part of the echo width, so it is counted too.
    assign timer_count = echo_sync && ((state == WAIT_RISE) || (state == MEASURE));
    assign dist_wr     = (state == FAIL) ? DIST_MAX : cm;
    assign BUSY        = (state != IDLE);

    us_echo_timer #(
        .CYCLES_PER_CM(CYCLES_PER_CM)
    ) u_echo_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .echo_in  (ECHO_IN),
        .sel      (idx),
        .clear    (timer_clear),
        .count_en (timer_count),
        .echo_sync(echo_sync),
        .cm       (cm)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state               <= IDLE;
            idx                 <= US_FRONT;
            rr_ptr              <= US_FRONT;
            cnt                 <= 32'd0;
            TRIG_OUT            <= 3'b000;
            TRIG_OE             <= 3'b000;
            DISTANCE_FRONT      <= 8'd0;
            DISTANCE_SIDE_FRONT <= 8'd0;
            DISTANCE_SIDE_BACK  <= 8'd0;
            VALID               <= 3'b000;
            TIMEOUT             <= 3'b000;
        end else begin
            VALID <= 3'b000;
            case (state)
                IDLE: begin
                    if (EN != 3'b000) begin
                        idx      <= pick;
                        rr_ptr   <= (pick == US_SIDE_BACK) ? US_FRONT : pick + 2'd1;
                        TRIG_OUT <= 3'b001 << pick;
                        TRIG_OE  <= 3'b001 << pick;
                        cnt      <= 32'd0;
                        state    <= TRIG;
                    end
                end
                TRIG: begin
                    if (cnt == 32'(TRIG_CYCLES - 1)) begin
                        TRIG_OUT <= 3'b000;
                        TRIG_OE  <= 3'b000;
                        cnt      <= 32'd0;
                        state    <= HOLDOFF;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLDOFF: begin
                    if (cnt == 32'(HOLDOFF_CYCLES - 1)) begin
                        cnt   <= 32'd0;
                        state <= WAIT_RISE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_RISE: begin
                    if (echo_sync) begin
                        cnt   <= 32'd0;
                        state <= MEASURE;
                    end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state <= FAIL;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                MEASURE: begin
                    if (!echo_sync) begin
                        state <= DONE;
                    end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state <= FAIL;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE, FAIL: begin
                    case (idx)
                        US_FRONT:      DISTANCE_FRONT      <= dist_wr;
                        US_SIDE_FRONT: DISTANCE_SIDE_FRONT <= dist_wr;
                        default:       DISTANCE_SIDE_BACK  <= dist_wr;
                    endcase
                    VALID        <= 3'b001 << idx;
                    TIMEOUT[idx] <= (state == FAIL);
                    cnt          <= 32'd0;
                    state        <= GUARD;
                end
                GUARD: begin
                    if (cnt == 32'(GUARD_CYCLES - 1)) begin
                        cnt   <= 32'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_us_ping_scheduler.sv
// tb/tb_us_ping_scheduler.sv - directed self-checking bench for us_ping_scheduler
module tb_us_ping_scheduler;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] EN;
    logic [2:0] ECHO_IN;
    logic [2:0] TRIG_OUT;
    logic [2:0] TRIG_OE;
    logic [7:0] DISTANCE_FRONT;
    logic [7:0] DISTANCE_SIDE_FRONT;
    logic [7:0] DISTANCE_SIDE_BACK;
    logic [2:0] VALID;
    logic [2:0] TIMEOUT;
    logic       BUSY;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int last_valid = 0;
    int oe1_cnt = 0;
    int onehot_viol = 0;

    always #5 CLK = ~CLK;

    us_ping_scheduler #(
        .TRIG_CYCLES   (4),
        .HOLDOFF_CYCLES(8),
        .CYCLES_PER_CM (10),
        .TIMEOUT_CYCLES(3000),
        .GUARD_CYCLES  (20)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .EN                 (EN),
        .ECHO_IN            (ECHO_IN),
        .TRIG_OUT           (TRIG_OUT),
        .TRIG_OE            (TRIG_OE),
        .DISTANCE_FRONT     (DISTANCE_FRONT),
        .DISTANCE_SIDE_FRONT(DISTANCE_SIDE_FRONT),
        .DISTANCE_SIDE_BACK (DISTANCE_SIDE_BACK),
        .VALID              (VALID),
        .TIMEOUT            (TIMEOUT),
        .BUSY               (BUSY)
    );

    always @(posedge CLK) begin
        #1;
        if (VALID != 3'b000) begin
            valid_cnt  = valid_cnt + 1;
            last_valid = int'(VALID);
        end
        if (TRIG_OE[1])
            oe1_cnt = oe1_cnt + 1;
        if ($countones(TRIG_OE) > 1)
            onehot_viol = onehot_viol + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got == exp)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int dist_of(input int s);
        case (s)
            0:       return int'(DISTANCE_FRONT);
            1:       return int'(DISTANCE_SIDE_FRONT);
            default: return int'(DISTANCE_SIDE_BACK);
        endcase
    endfunction

    task automatic do_ping(input int s, input int w, input int exp_d, input int exp_to, input bit stop);
        int n;
        int v0;
        n = 0;
        while (TRIG_OE == 3'b000 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check_eq($sformatf("trig_sel s%0d", s), int'(TRIG_OE), 1 << s);
        check_eq($sformatf("trig_out s%0d", s), int'(TRIG_OUT), 1 << s);
        if (stop)
            EN = 3'b000;
        v0 = valid_cnt;
        n = 0;
        while (TRIG_OE != 3'b000 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_eq($sformatf("trig_len s%0d", s), n, 4);
        repeat (15) @(negedge CLK);
        if (w > 0) begin
            ECHO_IN[s] = 1'b1;
            repeat (w) @(negedge CLK);
            ECHO_IN[s] = 1'b0;
        end
        n = 0;
        while (valid_cnt == v0 && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        check_eq($sformatf("valid_pulses s%0d", s), valid_cnt - v0, 1);
        check_eq($sformatf("valid_bit s%0d", s), last_valid, 1 << s);
        check_eq($sformatf("distance s%0d w%0d", s, w), dist_of(s), exp_d);
        check_eq($sformatf("timeout s%0d w%0d", s, w), int'(TIMEOUT[s]), exp_to);
    endtask

    initial begin
        int n;
        int oe1_before;
        int bad;
        RESET   = 1'b1;
        EN      = 3'b000;
        ECHO_IN = 3'b000;
        repeat (3) @(negedge CLK);
        check_eq("rst trig_oe", int'(TRIG_OE), 0);
        check_eq("rst trig_out", int'(TRIG_OUT), 0);
        check_eq("rst dist", int'(DISTANCE_FRONT) + int'(DISTANCE_SIDE_FRONT) + int'(DISTANCE_SIDE_BACK), 0);
        check_eq("rst valid", int'(VALID), 0);
        check_eq("rst timeout", int'(TIMEOUT), 0);
        check_eq("rst busy", int'(BUSY), 0);
        RESET = 1'b0;

        // All three sensors, distinct widths.
        EN = 3'b111;
        do_ping(0, 125, 12, 0, 1'b0);
        do_ping(1, 300, 30, 0, 1'b0);
        do_ping(2, 47, 4, 0, 1'b0);
        check_eq("timeout all", int'(TIMEOUT), 0);

        // Side-front disabled: front and side-back alternate.
        EN = 3'b101;
        oe1_before = oe1_cnt;
        do_ping(0, 200, 20, 0, 1'b0);
        do_ping(2, 200, 20, 0, 1'b0);
        do_ping(0, 200, 20, 0, 1'b0);
        do_ping(2, 200, 20, 0, 1'b0);
        check_eq("side_front idle", oe1_cnt - oe1_before, 0);

        // No echo, recovery, saturation and stuck-high pin on front.
        EN = 3'b001;
        do_ping(0, 0, 255, 1, 1'b0);
        do_ping(0, 50, 5, 0, 1'b0);
        do_ping(0, 2800, 255, 0, 1'b0);
        do_ping(0, 3100, 255, 1, 1'b1);
        n = 0;
        while (BUSY && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check_eq("busy after stuck", int'(BUSY), 0);

        // EN == 0 keeps the block idle; enabling one sensor triggers it right away.
        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (BUSY || TRIG_OE != 3'b000)
                bad++;
        end
        check_eq("en0 idle", bad, 0);
        EN = 3'b010;
        @(negedge CLK);
        check_eq("en010 first trig", int'(TRIG_OE), 2);
        do_ping(1, 80, 8, 0, 1'b0);

        // Reset in the middle of a measurement.
        EN = 3'b011;
        n = 0;
        while (TRIG_OE == 3'b000 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check_eq("pre-reset sel", int'(TRIG_OE), 1);
        n = 0;
        while (TRIG_OE != 3'b000 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        repeat (15) @(negedge CLK);
        ECHO_IN[0] = 1'b1;
        repeat (30) @(negedge CLK);
        check_eq("busy mid-measure", int'(BUSY), 1);
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("mid rst trig_oe", int'(TRIG_OE), 0);
        check_eq("mid rst busy", int'(BUSY), 0);
        check_eq("mid rst dist", int'(DISTANCE_FRONT) + int'(DISTANCE_SIDE_FRONT) + int'(DISTANCE_SIDE_BACK), 0);
        check_eq("mid rst timeout", int'(TIMEOUT), 0);
        ECHO_IN = 3'b000;
        @(negedge CLK);
        RESET = 1'b0;
        do_ping(0, 60, 6, 0, 1'b0);

        check_eq("trig_oe onehot", onehot_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
